tt_capture: RTL and testbench



---
 rtl/tt_pkg.sv | 16 +
 rtl/tt_sweep_cnt.sv | 43 ++++
 rtl/tt_capture.sv | 122 ++++++++++++
 tb/tb_tt_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table capture engine.
// The onset counter in tt_capture is compiled in only when TT_ONSET_COUNT_EN is defined.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    localparam int N_IN_DEF = 7;
    localparam int TT_W     = 2**N_IN_DEF;
    localparam int SETTLE_W = 4;

endpackage

// File: rtl/tt_sweep_cnt.sv
// Minterm index and per-minterm settle counter for the capture sweep.
// settled flags the cycle the held minterm may be sampled; last flags the final minterm.
module tt_sweep_cnt
    import tt_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            step,
    input  logic            adv,
    output logic [N_IN-1:0] index,
    output logic            settled,
    output logic            last
);

    localparam logic [SETTLE_W-1:0] SETTLE_C = SETTLE_W'(SETTLE);

    logic [SETTLE_W-1:0] cnt;

    // adv reloads the settle count at 1: the SAMPLE cycle itself is the last
    // cycle of each hold, so later minterms need only SETTLE more HOLD cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= '0;
            cnt   <= '0;
        end else if (clr) begin
            index <= '0;
            cnt   <= '0;
        end else if (adv) begin
            index <= index + N_IN'(1);
            cnt   <= SETTLE_W'(1);
        end else if (step) begin
            cnt   <= cnt + SETTLE_W'(1);
        end
    end

    assign settled = (cnt == SETTLE_C);
    assign last    = (index == {N_IN{1'b1}});

endmodule

// File: rtl/tt_capture.sv
// Truth-table capture: sweeps x over all minterms, samples f, and packs the result into tt.
// Define TT_ONSET_COUNT_EN to add the onset (ones-count) port and counter.
//
// state  | meaning
// IDLE   | waiting for start; x shows the last minterm driven
// HOLD   | minterm on x, waiting for f to settle (one extra cycle for minterm 0)
// SAMPLE | f captured into tt[x]; straight to the next SAMPLE when SETTLE is 0
// DONE   | one-cycle completion pulse; valid set
module tt_capture
    import tt_pkg::*;
#(
    parameter int N_IN   = 7,
    parameter int SETTLE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [N_IN-1:0]    x,
    input  logic               f,
    output logic               busy,
    output logic               done,
    output logic               valid,
    output logic [2**N_IN-1:0] tt
`ifdef TT_ONSET_COUNT_EN
    ,
    output logic [N_IN:0]      onset
`endif
);

    localparam bit NO_SETTLE = (SETTLE == 0);

    tt_state_e       state_q;
    tt_state_e       state_d;
    logic [N_IN-1:0] index;
    logic            settled;
    logic            last;
    logic            clr;
    logic            step;
    logic            adv;
    logic            capture;

    tt_sweep_cnt #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .step    (step),
        .adv     (adv),
        .index   (index),
        .settled (settled),
        .last    (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = HOLD;
            HOLD:    if (settled) state_d = SAMPLE;
            SAMPLE: begin
                if (last)           state_d = DONE;
                else if (NO_SETTLE) state_d = SAMPLE;
                else                state_d = HOLD;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clr     = 1'b0;
        step    = 1'b0;
        adv     = 1'b0;
        capture = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:   clr = start;
            HOLD: begin
                busy = 1'b1;
                step = !settled;
            end
            SAMPLE: begin
                busy    = 1'b1;
                capture = 1'b1;
                adv     = !last;
            end
            DONE:   done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt    <= '0;
            valid <= 1'b0;
        end else if (clr) begin
            tt    <= '0;
            valid <= 1'b0;
        end else if (capture) begin
            tt[index] <= f;
            if (last) valid <= 1'b1;
        end
    end

`ifdef TT_ONSET_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                onset <= '0;
        else if (clr)           onset <= '0;
        else if (capture && f)  onset <= onset + (N_IN+1)'(1);
    end
`endif

    assign x = index;

endmodule

// File: tb/tb_tt_capture.sv
// Self-checking bench for tt_capture: three instances (SETTLE 0, 1, 3) driven by
// behavioural functions of x; expected tables are computed minterm by minterm.
module tb_tt_capture;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_s [3];
    logic         f_s     [3];
    logic [6:0]   x_s     [3];
    logic         busy_s  [3];
    logic         done_s  [3];
    logic         valid_s [3];
    logic [127:0] tt_s    [3];
    logic [7:0]   onset_s [3];
    int           mode    [3];
    logic [127:0] rtab    [3];
    bit           regd    [3];

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // modes: 0 const 0, 1 const 1, 2 x0&x1, 3 x6, 4 random table lookup
    function automatic logic fval(input int m, input logic [127:0] t, input logic [6:0] xi);
        case (m)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return xi[0] & xi[1];
            3:       return xi[6];
            default: return t[xi];
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_fut
        logic fc;
        logic fr;
        assign fc = fval(mode[g], rtab[g], x_s[g]);
        always @(posedge clk) fr <= fc;
        assign f_s[g] = regd[g] ? fr : fc;
    end

    tt_capture #(.N_IN(7), .SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .x(x_s[0]), .f(f_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .valid(valid_s[0]), .tt(tt_s[0])
`ifdef TT_ONSET_COUNT_EN
        , .onset(onset_s[0])
`endif
    );
    tt_capture #(.N_IN(7), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .x(x_s[1]), .f(f_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .valid(valid_s[1]), .tt(tt_s[1])
`ifdef TT_ONSET_COUNT_EN
        , .onset(onset_s[1])
`endif
    );
    tt_capture #(.N_IN(7), .SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start_s[2]), .x(x_s[2]), .f(f_s[2]),
        .busy(busy_s[2]), .done(done_s[2]), .valid(valid_s[2]), .tt(tt_s[2])
`ifdef TT_ONSET_COUNT_EN
        , .onset(onset_s[2])
`endif
    );
`ifndef TT_ONSET_COUNT_EN
    initial for (int i = 0; i < 3; i++) onset_s[i] = '0;
`endif

    function automatic int settle_of(input int u);
        return (u == 0) ? 0 : ((u == 1) ? 1 : 3);
    endfunction

    // Expected table: entry i is the function evaluated at the minterm whose
    // value f presents while x == i (i-1 when f lags by a register).
    function automatic logic [127:0] model_tt(input int m, input logic [127:0] t, input bit lag);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) begin
            logic [6:0] src;
            src = (lag && i > 0) ? 7'(i - 1) : 7'(i);
            r[i] = fval(m, t, src);
        end
        return r;
    endfunction

    function automatic logic [7:0] popcnt(input logic [127:0] v);
        int c = 0;
        for (int i = 0; i < 128; i++) if (v[i]) c++;
        return 8'(c);
    endfunction

    // Starts a sweep at the current negedge and watches until one cycle after done.
    task automatic sweep(input int u, input int p1, input int p2, output int lat,
                         output int npulse, output int bad_hold, output logic v_start,
                         output logic b_start);
        int s;
        int budget;
        int run;
        logic [6:0] px;
        s = settle_of(u);
        budget = 128 * (s + 1) + 20;
        start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;
        v_start = valid_s[u];
        b_start = busy_s[u] && (x_s[u] == 7'd0);
        lat = -1; npulse = 0; bad_hold = 0; run = 1; px = x_s[u];
        for (int n = 1; n <= budget; n++) begin
            start_s[u] = (n == p1) || (n == p2);
            @(negedge clk);
            if (done_s[u]) begin
                npulse++;
                if (lat < 0) lat = n;
            end
            if (x_s[u] != px) begin
                if (px >= 7'd1 && px <= 7'd126 && run != s + 1) bad_hold++;
                px = x_s[u];
                run = 1;
            end else begin
                run++;
            end
            if (lat >= 0 && n >= lat + 1) break;
        end
        start_s[u] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            total++;
            if ({x_s[u], busy_s[u], done_s[u], valid_s[u]} !== 10'd0 || tt_s[u] !== '0 || onset_s[u] !== 8'd0)
                $display("FAIL reset_u%0d: got x=%h busy=%b done=%b valid=%b tt=%h onset=%0d want all zero",
                         u, x_s[u], busy_s[u], done_s[u], valid_s[u], tt_s[u], onset_s[u]);
            else passed++;
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0)
            $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", busy_s[0], done_s[0]);
        else passed++;
    endtask

    task automatic check_sweep(input string name, input int u, input int lat, input int npulse,
                               input logic [127:0] exp_tt, input int exp_lat);
        total++;
        if (lat !== exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
        else passed++;
        total++;
        if (npulse !== 1) $display("FAIL %s_done_pulses: got %0d want 1", name, npulse);
        else passed++;
        total++;
        if (tt_s[u] !== exp_tt) $display("FAIL %s_tt: got %h want %h", name, tt_s[u], exp_tt);
        else passed++;
        total++;
        if (valid_s[u] !== 1'b1) $display("FAIL %s_valid: got %b want 1", name, valid_s[u]);
        else passed++;
`ifdef TT_ONSET_COUNT_EN
        total++;
        if (onset_s[u] !== popcnt(exp_tt))
            $display("FAIL %s_onset: got %0d want %0d", name, onset_s[u], popcnt(exp_tt));
        else passed++;
`endif
    endtask

    task automatic test_and_s0();
        int lat, np, bh;
        logic vs, bs;
        mode[0] = 2;
        sweep(0, -1, -1, lat, np, bh, vs, bs);
        total++;
        if (bs !== 1'b1) $display("FAIL and_start_busy_x0: got %b want 1", bs);
        else passed++;
        check_sweep("and_s0", 0, lat, np, model_tt(2, '0, 1'b0), 129);
        total++;
        if (tt_s[0] !== 128'h8888_8888_8888_8888_8888_8888_8888_8888)
            $display("FAIL and_s0_literal: got %h want 8888...8888", tt_s[0]);
        else passed++;
    endtask

    task automatic test_x6_s3();
        int lat, np, bh;
        logic vs, bs;
        mode[2] = 3;
        sweep(2, -1, -1, lat, np, bh, vs, bs);
        check_sweep("x6_s3", 2, lat, np, model_tt(3, '0, 1'b0), 513);
        total++;
        if (bh !== 0) $display("FAIL x6_s3_hold_len: got %0d bad holds want 0", bh);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int lat, np, bh;
        logic vs, bs;
        mode[0] = 0;
        sweep(0, -1, -1, lat, np, bh, vs, bs);
        check_sweep("const0", 0, lat, np, '0, 129);
        mode[0] = 1;
        sweep(0, -1, -1, lat, np, bh, vs, bs);
        total++;
        if (vs !== 1'b0) $display("FAIL b2b_valid_drop: got %b want 0", vs);
        else passed++;
        check_sweep("const1", 0, lat, np, {128{1'b1}}, 129);
    endtask

    task automatic test_ignore_start();
        int lat, np, bh;
        logic vs, bs;
        int stray;
        mode[0] = 4;
        rtab[0] = {$urandom, $urandom, $urandom, $urandom};
        sweep(0, 10, 50, lat, np, bh, vs, bs);
        check_sweep("ignore_start", 0, lat, np, model_tt(4, rtab[0], 1'b0), 129);
        stray = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy_s[0] || done_s[0]) stray++;
        end
        total++;
        if (stray !== 0) $display("FAIL ignore_start_queued: got %0d busy/done cycles want 0", stray);
        else passed++;
    endtask

    task automatic test_rst_mid();
        int lat, np, bh, stray;
        logic vs, bs;
        mode[0] = 4;
        rtab[0] = {$urandom, $urandom, $urandom, $urandom};
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (59) @(negedge clk);
        total++;
        if (busy_s[0] !== 1'b1) $display("FAIL rst_mid_pre_busy: got %b want 1", busy_s[0]);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (x_s[0] !== 7'd0 || busy_s[0] !== 1'b0 || valid_s[0] !== 1'b0 || tt_s[0] !== '0)
            $display("FAIL rst_mid_clear: got x=%h busy=%b valid=%b tt=%h want 0 0 0 0",
                     x_s[0], busy_s[0], valid_s[0], tt_s[0]);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done_s[0] || busy_s[0]) stray++;
        end
        total++;
        if (stray !== 0) $display("FAIL rst_mid_no_done: got %0d busy/done cycles want 0", stray);
        else passed++;
        sweep(0, -1, -1, lat, np, bh, vs, bs);
        check_sweep("rst_resweep", 0, lat, np, model_tt(4, rtab[0], 1'b0), 129);
    endtask

    task automatic test_registered();
        int lat, np, bh;
        logic vs, bs;
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        mode[0] = 4; rtab[0] = t; regd[0] = 1'b1;
        mode[1] = 4; rtab[1] = t; regd[1] = 1'b1;
        repeat (2) @(negedge clk);
        sweep(0, -1, -1, lat, np, bh, vs, bs);
        check_sweep("reg_s0_shift", 0, lat, np, model_tt(4, t, 1'b1), 129);
        sweep(1, -1, -1, lat, np, bh, vs, bs);
        check_sweep("reg_s1", 1, lat, np, model_tt(4, t, 1'b0), 257);
        regd[0] = 1'b0;
        regd[1] = 1'b0;
    endtask

    task automatic test_random();
        int lat, np, bh, u;
        logic vs, bs;
        for (int k = 0; k < 4; k++) begin
            u = k % 3;
            mode[u] = 4;
            rtab[u] = {$urandom, $urandom, $urandom, $urandom};
            sweep(u, -1, -1, lat, np, bh, vs, bs);
            check_sweep("random", u, lat, np, model_tt(4, rtab[u], 1'b0), 128 * (settle_of(u) + 1) + 1);
            total++;
            if (bh !== 0) $display("FAIL random_hold_len_u%0d: got %0d want 0", u, bh);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0;
            mode[i] = 0;
            rtab[i] = '0;
            regd[i] = 1'b0;
        end
        test_reset();
        test_and_s0();
        test_x6_s3();
        test_back_to_back();
        test_ignore_start();
        test_rst_mid();
        test_registered();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
